// File: rtl/tiny_proc_pkg.sv
// Shared encodings for the tiny processor's serial load/run port and its loader.
// Holds select codes, command kinds, frame geometry and the loader state enumeration.
package tiny_proc_pkg;

    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned FRAME_W = ADDR_W + DATA_W;

    localparam logic [1:0] SEL_IDLE = 2'b00;
    localparam logic [1:0] SEL_ICS  = 2'b01;
    localparam logic [1:0] SEL_DCS  = 2'b10;
    localparam logic [1:0] SEL_RUN  = 2'b11;

    localparam logic [1:0] CMD_IWR = 2'd0;
    localparam logic [1:0] CMD_DWR = 2'd1;
    localparam logic [1:0] CMD_RUN = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_RUN
    } state_e;

endpackage

// File: rtl/spi_frame_tx.sv
// Serialiser for one {data, addr} write frame, LSB first, one bit per cycle.
// mosi is registered and parks at 0 whenever no frame is being shifted.
module spi_frame_tx
    import tiny_proc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               shift_i,
    output logic               mosi_o,
    output logic               last_o
);

    localparam int unsigned CNT_W = $clog2(FRAME_W);

    logic [FRAME_W-1:0] shreg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               mosi_q;

    // Bit 0 goes out on the load edge so the first bit appears one cycle after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            mosi_q  <= 1'b0;
        end else if (load_i) begin
            mosi_q  <= frame_i[0];
            shreg_q <= frame_i >> 1;
            cnt_q   <= '0;
        end else if (shift_i && !last_o) begin
            mosi_q  <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
            cnt_q   <= cnt_q + 1'b1;
        end else begin
            mosi_q  <= 1'b0;
        end
    end

    assign last_o = (cnt_q == CNT_W'(FRAME_W - 1));
    assign mosi_o = mosi_q;

endmodule

// File: rtl/spi_prog_loader.sv
// Upstream master for the processor load/run port: serialises cache writes and supervises runs.
// Optional run watchdog enabled by defining SPI_PROG_LOADER_RUN_TIMEOUT_EN.
module spi_prog_loader
    import tiny_proc_pkg::*;
#(
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned MIN_RUN_CYCLES = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_kind,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [1:0]        sel,
    output logic              mosi,
    input  logic              proc_done,
    output logic              busy,
    output logic              run_done,
    output logic              run_timeout
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES);
    localparam int unsigned RUN_W = $clog2(MIN_RUN_CYCLES + 1);

    if (GAP_CYCLES < 2 || MIN_RUN_CYCLES < 1 || TIMEOUT_CYCLES > 4096 ||
        TIMEOUT_CYCLES <= MIN_RUN_CYCLES + 1) begin : g_bad_cfg
        $error("spi_prog_loader: unsupported parameter combination");
    end

    state_e           state_q;
    logic [1:0]       sel_q;
    logic             cmd_ready_q;
    logic             busy_q;
    logic             run_done_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [RUN_W-1:0] run_cnt_q;

    logic accept;
    logic load;
    logic frame_last;
    logic done_seen;

    assign accept     = cmd_valid && cmd_ready_q;
    assign load       = accept && (cmd_kind == CMD_IWR || cmd_kind == CMD_DWR);
    assign done_seen  = (run_cnt_q == RUN_W'(MIN_RUN_CYCLES)) && proc_done;

    spi_frame_tx u_frame_tx (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .frame_i ({cmd_data, cmd_addr}),
        .shift_i (state_q == ST_SHIFT),
        .mosi_o  (mosi),
        .last_o  (frame_last)
    );

`ifdef SPI_PROG_LOADER_RUN_TIMEOUT_EN
    logic [11:0] wd_q;
    logic        wd_expired;
    logic        run_timeout_q;

    // Held at zero outside RUN, so it reads 0 in the first RUN cycle.
    always_ff @(posedge clk) begin
        if (rst || state_q != ST_RUN) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end

    assign wd_expired  = (wd_q == 12'(TIMEOUT_CYCLES - 1));
    assign run_timeout = run_timeout_q;
`else
    assign run_timeout = 1'b0;
`endif

    // Every exit from SHIFT or RUN goes through GAP, so sel always passes through 00.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sel_q         <= SEL_IDLE;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            run_done_q    <= 1'b0;
            gap_cnt_q     <= '0;
            run_cnt_q     <= '0;
`ifdef SPI_PROG_LOADER_RUN_TIMEOUT_EN
            run_timeout_q <= 1'b0;
`endif
        end else begin
            run_done_q    <= 1'b0;
`ifdef SPI_PROG_LOADER_RUN_TIMEOUT_EN
            run_timeout_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (cmd_kind)
                            CMD_IWR, CMD_DWR: begin
                                state_q     <= ST_SHIFT;
                                sel_q       <= (cmd_kind == CMD_IWR) ? SEL_ICS : SEL_DCS;
                                cmd_ready_q <= 1'b0;
                                busy_q      <= 1'b1;
                            end
                            CMD_RUN: begin
                                state_q     <= ST_RUN;
                                sel_q       <= SEL_RUN;
                                run_cnt_q   <= '0;
                                cmd_ready_q <= 1'b0;
                                busy_q      <= 1'b1;
                            end
                            default: begin
                                state_q <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_SHIFT: begin
                    if (frame_last) begin
                        state_q   <= ST_GAP;
                        sel_q     <= SEL_IDLE;
                        gap_cnt_q <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (run_cnt_q != RUN_W'(MIN_RUN_CYCLES)) begin
                        run_cnt_q <= run_cnt_q + 1'b1;
                    end
                    // Releasing sel right after done keeps the processor from restarting.
                    if (done_seen) begin
                        state_q    <= ST_GAP;
                        sel_q      <= SEL_IDLE;
                        gap_cnt_q  <= '0;
                        run_done_q <= 1'b1;
                    end
`ifdef SPI_PROG_LOADER_RUN_TIMEOUT_EN
                    else if (wd_expired) begin
                        state_q       <= ST_GAP;
                        sel_q         <= SEL_IDLE;
                        gap_cnt_q     <= '0;
                        run_done_q    <= 1'b1;
                        run_timeout_q <= 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel       = sel_q;
    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign run_done  = run_done_q;

endmodule

// File: tb/tb_spi_prog_loader.sv
// Scoreboard bench for spi_prog_loader: stimulus queues expected frames/runs, a monitor
// decodes sel/mosi like the attached processor and checks each one as it completes.
module tb_spi_prog_loader;
    import tiny_proc_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_kind = 2'd0;
    logic [3:0] cmd_addr = 4'd0;
    logic [7:0] cmd_data = 8'd0;
    logic [1:0] sel;
    logic       mosi;
    logic       proc_done = 1'b0;
    logic       busy;
    logic       run_done;
    logic       run_timeout;

    always #5 clk = ~clk;

    spi_prog_loader #(
        .GAP_CYCLES     (2),
        .MIN_RUN_CYCLES (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_kind    (cmd_kind),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .sel         (sel),
        .mosi        (mosi),
        .proc_done   (proc_done),
        .busy        (busy),
        .run_done    (run_done),
        .run_timeout (run_timeout)
    );

    // kind 3 marks a frame cut short by reset; only its bit count is checked.
    typedef struct {
        logic [1:0]  kind;
        logic [11:0] frame;
        int          len;
        logic        tmo;
    } exp_t;

    exp_t       expQ[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] icache[16];
    logic [7:0] dcache[16];
    bit         monOn = 1'b0;
    int         runPulses = 0;
    int         expRuns = 0;
    logic [1:0] prevSel = 2'b00;
    int         bitCnt = 0;
    logic [11:0] shFrame = 12'd0;
    int         runLen = 0;
    int         zeroRun = 100;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic [1:0] kind, input logic [11:0] frame, input int len, input logic tmo);
        exp_t e;
        e.kind  = kind;
        e.frame = frame;
        e.len   = len;
        e.tmo   = tmo;
        expQ.push_back(e);
    endtask

    task automatic endFrame(input logic [1:0] code);
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput("unexpectedFrame", {30'd0, code}, 32'd0);
            return;
        end
        e = expQ.pop_front();
        if (e.kind == 2'd3) begin
            checkOutput("abortedBits", bitCnt, e.len);
        end else begin
            checkOutput("frameKind", (code == SEL_ICS) ? 32'd0 : 32'd1, {30'd0, e.kind});
            checkOutput("frameBits", bitCnt, 32'd12);
            checkOutput("frameData", {20'd0, shFrame}, {20'd0, e.frame});
            checkOutput("gapMosi", {31'd0, mosi}, 32'd0);
            if (bitCnt == 12) begin
                if (code == SEL_ICS) icache[shFrame[3:0]] = shFrame[11:4];
                else                 dcache[shFrame[3:0]] = shFrame[11:4];
            end
        end
    endtask

    task automatic endRun();
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput("unexpectedRun", 32'd1, 32'd0);
            return;
        end
        e = expQ.pop_front();
        checkOutput("runKind", {30'd0, e.kind}, 32'd2);
        checkOutput("runLen", runLen, e.len);
        checkOutput("runDone", {31'd0, run_done}, 32'd1);
        checkOutput("runTimeout", {31'd0, run_timeout}, {31'd0, e.tmo});
        if (run_done) runPulses++;
    endtask

    // Monitor: behaves like the processor port, sampling on the falling edge.
    always @(negedge clk) begin
        if (monOn) begin
            if (prevSel != SEL_IDLE && sel != SEL_IDLE && sel != prevSel)
                checkOutput("selViaIdle", {30'd0, sel}, {30'd0, SEL_IDLE});
            if (sel == SEL_ICS || sel == SEL_DCS) begin
                if (prevSel == SEL_IDLE) begin
                    bitCnt  = 0;
                    shFrame = 12'd0;
                    checkOutput("gapLen", (zeroRun >= 2) ? 32'd1 : 32'd0, 32'd1);
                end
                if (bitCnt < 12) shFrame[bitCnt] = mosi;
                bitCnt++;
            end else if (sel == SEL_RUN) begin
                if (prevSel == SEL_IDLE) begin
                    runLen = 0;
                    checkOutput("gapLen", (zeroRun >= 2) ? 32'd1 : 32'd0, 32'd1);
                end
                runLen++;
            end
            if (sel == SEL_IDLE) zeroRun++;
            else                 zeroRun = 0;
            if (sel == SEL_IDLE && (prevSel == SEL_ICS || prevSel == SEL_DCS)) begin
                endFrame(prevSel);
            end
            if (sel == SEL_IDLE && prevSel == SEL_RUN) begin
                endRun();
            end else if (run_done || run_timeout) begin
                checkOutput("strayRunPulse", {30'd0, run_done, run_timeout}, 32'd0);
            end
            prevSel = sel;
        end
    end

    // Called on a falling edge; returns on the falling edge of the first cycle after acceptance.
    task automatic applyStimulus(input logic [1:0] kind, input logic [3:0] addr, input logic [7:0] data,
                                 input bit keepValid);
        int waitCnt = 0;
        cmd_valid = 1'b1;
        cmd_kind  = kind;
        cmd_addr  = addr;
        cmd_data  = data;
        while (!cmd_ready && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("acceptReady", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (!keepValid) begin
            cmd_valid = 1'b0;
            cmd_addr  = ~addr;
            cmd_data  = ~data;
        end
        if (kind == CMD_IWR)      checkOutput("firstSelI", {30'd0, sel}, {30'd0, SEL_ICS});
        else if (kind == CMD_DWR) checkOutput("firstSelD", {30'd0, sel}, {30'd0, SEL_DCS});
        else if (kind == CMD_RUN) checkOutput("firstSelR", {30'd0, sel}, {30'd0, SEL_RUN});
        if (kind == 2'd3) begin
            checkOutput("reservedBusy", {31'd0, busy}, 32'd0);
            checkOutput("reservedReady", {31'd0, cmd_ready}, 32'd1);
        end else begin
            checkOutput("busyAfterAccept", {31'd0, busy}, 32'd1);
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((busy || !cmd_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idleReached", {30'd0, busy, cmd_ready}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int lowCnt;
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("rstSel", {30'd0, sel}, 32'd0);
        checkOutput("rstMosi", {31'd0, mosi}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstRunDone", {31'd0, run_done}, 32'd0);
        checkOutput("rstRunTimeout", {31'd0, run_timeout}, 32'd0);
        checkOutput("rstReady", {31'd0, cmd_ready}, 32'd1);
        monOn = 1'b1;
        @(negedge clk);

        pushExp(2'd0, 12'hA53, 12, 1'b0);
        applyStimulus(CMD_IWR, 4'h3, 8'hA5, 1'b0);
        waitIdle();

        pushExp(2'd1, 12'h80F, 12, 1'b0);
        applyStimulus(CMD_DWR, 4'hF, 8'h80, 1'b0);
        lowCnt = 0;
        while (!cmd_ready && lowCnt < 100) begin
            lowCnt++;
            @(negedge clk);
        end
        checkOutput("readyLowCycles", lowCnt, 32'd14);
        waitIdle();

        pushExp(2'd0, 12'h3C1, 12, 1'b0);
        pushExp(2'd1, 12'hC32, 12, 1'b0);
        pushExp(2'd0, 12'h5A7, 12, 1'b0);
        applyStimulus(CMD_IWR, 4'h1, 8'h3C, 1'b1);
        applyStimulus(CMD_DWR, 4'h2, 8'hC3, 1'b1);
        applyStimulus(CMD_IWR, 4'h7, 8'h5A, 1'b0);
        waitIdle();

        applyStimulus(2'd3, 4'h6, 8'hFF, 1'b0);
        waitIdle();

        pushExp(2'd2, 12'h000, 20, 1'b0);
        expRuns++;
        applyStimulus(CMD_RUN, 4'h0, 8'h00, 1'b0);
        repeat (19) @(negedge clk);
        proc_done = 1'b1;
        n = 0;
        while (sel != SEL_IDLE && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("runReleased", {30'd0, sel}, {30'd0, SEL_IDLE});
        proc_done = 1'b0;
        waitIdle();

        pushExp(2'd3, 12'h000, 6, 1'b0);
        applyStimulus(CMD_IWR, 4'h4, 8'h77, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midRstSel", {30'd0, sel}, 32'd0);
        checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
        checkOutput("midRstReady", {31'd0, cmd_ready}, 32'd1);
        checkOutput("midRstMosi", {31'd0, mosi}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        pushExp(2'd1, 12'h429, 12, 1'b0);
        applyStimulus(CMD_DWR, 4'h9, 8'h42, 1'b0);
        waitIdle();

`ifdef SPI_PROG_LOADER_RUN_TIMEOUT_EN
        pushExp(2'd2, 12'h000, 16, 1'b1);
        expRuns++;
        applyStimulus(CMD_RUN, 4'h0, 8'h00, 1'b0);
        n = 0;
        while (sel != SEL_IDLE && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeoutReleased", {30'd0, sel}, {30'd0, SEL_IDLE});
        waitIdle();
`endif

        repeat (4) @(negedge clk);
        checkOutput("queueEmpty", expQ.size(), 32'd0);
        checkOutput("icache3", {24'd0, icache[3]}, 32'hA5);
        checkOutput("dcache15", {24'd0, dcache[15]}, 32'h80);
        checkOutput("icache1", {24'd0, icache[1]}, 32'h3C);
        checkOutput("dcache2", {24'd0, dcache[2]}, 32'hC3);
        checkOutput("icache7", {24'd0, icache[7]}, 32'h5A);
        checkOutput("dcache9", {24'd0, dcache[9]}, 32'h42);
        checkOutput("runPulses", runPulses, expRuns);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: got no finish, expected finish before 200000");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
